// File: rtl/sigma_mem_pkg.sv
// rtl/sigma_mem_pkg.sv - shared types and constants for the Sigma memory responder
// Purpose: loader state encoding, byte-lane geometry and the default array depth.
// Ports: none (package).
package sigma_mem_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 16384;
    localparam int ADDR_W              = 17;
    localparam int LANE_W              = 8;
    localparam int NUM_LANES           = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOAD,
        ST_WRITE,
        ST_RELEASE
    } load_state_e;

    // Lane 0 is the most significant byte of a word held as [31:0].
    function automatic int lane_msb(input int lane);
        return 31 - LANE_W * lane;
    endfunction

endpackage

// File: rtl/sigma_memory_if.sv
// rtl/sigma_memory_if.sv - CPU memory bus plus host loader stream
// Purpose: bundles the CPU word bus and the loader byte stream.
// Ports (signals): memory_address, write_data, wr_enables, read_data (CPU bus);
//   load_start, load_base, load_count, load_byte, load_valid, load_ready (loader).
// Modports: master = CPU/host side, slave = memory side.
interface sigma_memory_if;

    logic [15:31] memory_address;
    logic [0:31]  write_data;
    logic [0:3]   wr_enables;
    logic [0:31]  read_data;
    logic         load_start;
    logic [15:31] load_base;
    logic [16:0]  load_count;
    logic [0:7]   load_byte;
    logic         load_valid;
    logic         load_ready;

    modport master (
        output memory_address, write_data, wr_enables,
        output load_start, load_base, load_count, load_byte, load_valid,
        input  read_data, load_ready
    );

    modport slave (
        input  memory_address, write_data, wr_enables,
        input  load_start, load_base, load_count, load_byte, load_valid,
        output read_data, load_ready
    );

endinterface

// File: rtl/sigma_load_assembler.sv
// rtl/sigma_load_assembler.sv - packs a big-endian byte stream into 32-bit words
// Purpose: byte shift register, byte index and a one-cycle word_valid strobe.
// Ports: clock, reset (sync, active-high); byte_i, accept_i (byte taken this cycle);
//   word_o (assembled word), word_valid_o (high the cycle after the 4th byte),
//   last_byte_o (next accepted byte completes the word).
module sigma_load_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_i,
    input  logic        accept_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        last_byte_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (accept_i) begin
            word_d  = {word_q[23:0], byte_i};
            idx_d   = idx_q + 2'd1;
            valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign last_byte_o  = (idx_q == 2'd3);

endmodule

// File: rtl/sigma_memory.sv
// rtl/sigma_memory.sv - Sigma CPU memory responder with host program loader
// Purpose: word array with byte-lane CPU writes and combinational reads; a loader
//   FSM that writes assembled words and holds the CPU in reset while loading.
// Ports: clock, reset (sync, active-high); bus (slave side of sigma_memory_if);
//   cpu_reset (to CPU reset input), loading (state not IDLE), bus_error (sticky).
module sigma_memory
    import sigma_mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = DEFAULT_DEPTH_WORDS,
    parameter     INIT_FILE      = "",
    parameter bit HOLD_ON_RESET  = 1'b1,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    sigma_memory_if.slave bus,
    output logic          cpu_reset,
    output logic          loading,
    output logic          bus_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

    logic [31:0] mem_q [0:DEPTH_WORDS-1];

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [16:0]       rem_q, rem_d;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic              berr_q, berr_d;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_in_range, load_in_range, cpu_we;
    logic [31:0]       asm_word;
    logic              asm_valid, asm_last, accept;

    assign cpu_addr      = bus.memory_address;
    assign cpu_in_range  = ({15'd0, cpu_addr} < 32'(DEPTH_WORDS));
    assign load_in_range = ({15'd0, ptr_q} < 32'(DEPTH_WORDS));
    assign cpu_reset     = (state_q != ST_IDLE);
    assign loading       = (state_q != ST_IDLE);
    assign bus_error     = berr_q;
    assign cpu_we        = !cpu_reset && (bus.wr_enables != 4'd0);
    assign accept        = bus.load_valid && (state_q == ST_LOAD);
    assign bus.load_ready = (state_q == ST_LOAD);
    assign bus.read_data  = cpu_in_range ? mem_q[cpu_addr[IDX_W-1:0]] : 32'd0;

    sigma_load_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .byte_i       (bus.load_byte),
        .accept_i     (accept),
        .word_o       (asm_word),
        .word_valid_o (asm_valid),
        .last_byte_o  (asm_last)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        rel_d   = rel_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (bus.load_start) begin
                    ptr_d   = bus.load_base;
                    rem_d   = bus.load_count;
                    berr_d  = 1'b0;
                    state_d = (bus.load_count != 17'd0) ? ST_LOAD : ST_RELEASE;
                end
            end
            ST_LOAD: begin
                if (accept && asm_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ptr_d   = ptr_q + 17'd1;
                rem_d   = rem_q - 17'd1;
                state_d = (rem_q == 17'd1) ? ST_RELEASE : ST_LOAD;
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
                    rel_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An error in the same cycle as a load_start still latches.
        if ((cpu_we && !cpu_in_range) || (asm_valid && !load_in_range)) berr_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD_ON_RESET ? ST_HOLD : ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            rel_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            rel_q   <= rel_d;
            berr_q  <= berr_d;
        end
    end

    // Loader and CPU writes never coincide: the CPU is held whenever the loader writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (asm_valid && load_in_range) begin
                mem_q[ptr_q[IDX_W-1:0]] <= asm_word;
            end else if (cpu_we && cpu_in_range) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (bus.wr_enables[i])
                        mem_q[cpu_addr[IDX_W-1:0]][lane_msb(i) -: LANE_W] <=
                            bus.write_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_memory.sv
// tb/tb_sigma_memory.sv - self-checking bench for sigma_memory
module tb_sigma_memory;

    localparam int DEPTH = 16384;
    localparam int R     = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, loading, bus_error;

    sigma_memory_if bus ();

    sigma_memory #(
        .DEPTH_WORDS    (DEPTH),
        .INIT_FILE      (""),
        .HOLD_ON_RESET  (1'b1),
        .RELEASE_CYCLES (R)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .loading   (loading),
        .bus_error (bus_error)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as a sparse word map, loader as a byte queue and
    // counters of words outstanding and release cycles left.
    logic [31:0] mdl_mem [int];
    bit          m_ok = 0, m_hold, m_wpend, m_berr;
    int          m_words, m_rel;
    logic [16:0] m_ptr;
    logic [7:0]  m_bytes [$];
    logic [31:0] m_w, m_mask, m_word;
    bit          m_clr, m_set, m_busy;

    always @(posedge clock) begin
        if (reset) begin
            m_hold = 1; m_words = 0; m_wpend = 0; m_rel = 0; m_berr = 0;
            m_bytes.delete();
            m_ok = 1;
        end else if (m_ok) begin
            m_clr = 0; m_set = 0;
            if (!m_hold && bus.wr_enables != 4'd0) begin
                if (int'(bus.memory_address) < DEPTH) begin
                    m_w = mdl_mem.exists(int'(bus.memory_address)) ?
                          mdl_mem[int'(bus.memory_address)] : 32'hxxxxxxxx;
                    m_mask = 32'd0;
                    for (int i = 0; i < 4; i++)
                        if (bus.wr_enables[i]) m_mask = m_mask | (32'hFF000000 >> (8 * i));
                    m_w = (m_w & ~m_mask) | (bus.write_data & m_mask);
                    mdl_mem[int'(bus.memory_address)] = m_w;
                end else begin
                    m_set = 1;
                end
            end
            m_busy = (m_words > 0) || m_wpend || (m_rel > 0);
            if (!m_busy) begin
                if (bus.load_start) begin
                    m_clr = 1; m_ptr = bus.load_base; m_words = int'(bus.load_count); m_hold = 1;
                    if (m_words == 0) m_rel = R;
                end
            end else if (m_wpend) begin
                if (int'(m_ptr) < DEPTH) mdl_mem[int'(m_ptr)] = m_word;
                else m_set = 1;
                m_ptr = m_ptr + 17'd1; m_words--; m_wpend = 0;
                if (m_words == 0) m_rel = R;
            end else if (m_words > 0) begin
                if (bus.load_valid) m_bytes.push_back(bus.load_byte);
                if (m_bytes.size() == 4) begin
                    m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_bytes.delete();
                    m_wpend = 1;
                end
            end else begin
                m_rel--;
                if (m_rel == 0) m_hold = 0;
            end
            if (m_clr) m_berr = 0;
            if (m_set) m_berr = 1;
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            chk("cpu_reset", cpu_reset, m_hold);
            chk("loading", loading, m_hold);
            chk("load_ready", bus.load_ready, m_hold && m_words > 0 && !m_wpend && m_rel == 0);
            chk("bus_error", bus_error, m_berr);
            if (int'(bus.memory_address) >= DEPTH)
                chk("read_oor", bus.read_data, 32'd0);
            else if (mdl_mem.exists(int'(bus.memory_address)) &&
                     !$isunknown(mdl_mem[int'(bus.memory_address)]))
                chk("read_data", bus.read_data, mdl_mem[int'(bus.memory_address)]);
        end
    end

    logic [7:0] stream [$];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic [16:0] base, input logic [16:0] cnt);
        bus.load_start = 1'b1; bus.load_base = base; bus.load_count = cnt;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic send(input int nsend, input bit gaps);
        for (int k = 0; k < nsend; k++) begin
            bit acc = 0;
            int n = 0;
            bus.load_byte = stream[k];
            while (!acc && n < 200) begin
                bus.load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clock);
                acc = bus.load_valid && bus.load_ready;
                step();
                n++;
            end
            if (!acc) chk("send_timeout", 32'd0, 32'd1);
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (cpu_reset !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("release_timeout", cpu_reset, 1'b0);
        step();
    endtask

    task automatic rd(input string name, input logic [16:0] a, input logic [31:0] exp);
        bus.memory_address = a;
        @(negedge clock);
        chk(name, bus.read_data, exp);
    endtask

    task automatic cpu_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] en);
        bus.memory_address = a; bus.write_data = d; bus.wr_enables = en;
        step();
        bus.wr_enables = 4'd0;
    endtask

    initial begin
        bus.memory_address = '0; bus.write_data = '0; bus.wr_enables = '0;
        bus.load_start = 0; bus.load_base = '0; bus.load_count = '0;
        bus.load_byte = '0; bus.load_valid = 0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state: held in HOLD
        @(negedge clock);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_loading", loading, 1'b1);
        chk("rst_load_ready", bus.load_ready, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        step();

        // Boot load of two words, then exact release timing
        start_load(17'h20, 17'd2);
        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send(8, 0);
        @(negedge clock);
        chk("write_ready_low", bus.load_ready, 1'b0);
        for (int i = 0; i < R; i++) begin
            step();
            @(negedge clock);
            chk("release_hold", cpu_reset, 1'b1);
        end
        step();
        @(negedge clock);
        chk("release_fall", cpu_reset, 1'b0);
        rd("boot_w0", 17'h20, 32'h12345678);
        rd("boot_w1", 17'h21, 32'h9ABCDEF0);
        step();

        // Byte lanes
        start_load(17'h10, 17'd1);
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        send(4, 0);
        wait_idle();
        bus.memory_address = 17'h10; bus.write_data = 32'hAABBCCDD; bus.wr_enables = 4'b0101;
        @(negedge clock);
        chk("lane_old", bus.read_data, 32'h00000000);
        step();
        bus.wr_enables = 4'd0;
        @(negedge clock);
        chk("lane_new", bus.read_data, 32'h00BB00DD);
        step();
        cpu_wr(17'h0, 32'h01020304, 4'b1111);

        // Out of range write
        bus.memory_address = 17'h04000; bus.write_data = 32'hFFFFFFFF; bus.wr_enables = 4'b1111;
        @(negedge clock);
        chk("oor_read", bus.read_data, 32'd0);
        step();
        bus.wr_enables = 4'd0;
        @(negedge clock);
        chk("oor_berr", bus_error, 1'b1);
        rd("oor_word0", 17'h0, 32'h01020304);
        step();

        // Restart with count 0: CPU writes ignored while held
        start_load(17'h0, 17'd0);
        bus.memory_address = 17'h10; bus.write_data = 32'hFFFFFFFF; bus.wr_enables = 4'b1111;
        for (int i = 0; i < R; i++) begin
            @(negedge clock);
            chk("restart_hold", cpu_reset, 1'b1);
            chk("restart_berr_clr", bus_error, 1'b0);
            if (i == R - 1) bus.wr_enables = 4'd0;
            step();
        end
        @(negedge clock);
        chk("restart_fall", cpu_reset, 1'b0);
        chk("restart_mem", bus.read_data, 32'h00BB00DD);
        step();

        // Backpressure with random gaps
        start_load(17'h30, 17'd3);
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                   8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        send(12, 1);
        wait_idle();
        rd("bp_w0", 17'h30, 32'h11223344);
        rd("bp_w1", 17'h31, 32'h55667788);
        rd("bp_w2", 17'h32, 32'h99AABBCC);
        step();

        // Reset in the middle of word 2 of a 3-word load
        cpu_wr(17'h42, 32'h5A5A5A5A, 4'b1111);
        start_load(17'h40, 17'd3);
        stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02};
        send(10, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_cpu_reset", cpu_reset, 1'b1);
        chk("mid_ready", bus.load_ready, 1'b0);
        rd("mid_w0", 17'h40, 32'hDEADBEEF);
        rd("mid_w1", 17'h41, 32'hCAFEBABE);
        rd("mid_w2", 17'h42, 32'h5A5A5A5A);
        step();
        start_load(17'h42, 17'd1);
        stream = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        send(4, 0);
        wait_idle();
        rd("mid_reload", 17'h42, 32'h0A0B0C0D);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
